// File: rtl/eeg_epoch_streamer_if.sv
// Bundle between the ADC front-end, the epoch streamer and the CIM SoC
// control interface. The streamer uses the master modport; the slave is its peer.
interface eeg_epoch_streamer_if #(
   parameter int unsigned ADC_W = 16
);
   logic             enable;
   logic             adc_valid;
   logic [ADC_W-1:0] adc_data;
   logic             adc_ready;
   logic             new_sleep_epoch;
   logic             start_eeg_load;
   logic             new_eeg_data;
   logic [ADC_W-1:0] eeg;
   logic             inference_complete;
   logic             busy;
   logic             overflow;
   logic [15:0]      epoch_count;

   modport master (
      input  enable, adc_valid, adc_data, inference_complete,
      output adc_ready, new_sleep_epoch, start_eeg_load, new_eeg_data,
             eeg, busy, overflow, epoch_count
   );

   modport slave (
      output enable, adc_valid, adc_data, inference_complete,
      input  adc_ready, new_sleep_epoch, start_eeg_load, new_eeg_data,
             eeg, busy, overflow, epoch_count
   );
endinterface

// File: rtl/eeg_epoch_streamer.sv
// Buffers ADC samples in a FIFO and streams one paced epoch of samples per
// sleep epoch to the CIM, then waits for inference_complete.
module eeg_epoch_streamer #(
   parameter int unsigned ADC_W             = 16,
   parameter int unsigned SAMPLES_PER_EPOCH = 3000,
   parameter int unsigned FIFO_DEPTH        = 16,
   parameter int unsigned LOAD_GAP          = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   eeg_epoch_streamer_if.master bus
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned GW = 4;
   localparam int unsigned SW = 16;

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_EPOCH    = 3'd1;
   localparam logic [2:0] S_LOAD     = 3'd2;
   localparam logic [2:0] S_STREAM   = 3'd3;
   localparam logic [2:0] S_WAIT_INF = 3'd4;

   logic [2:0]       state, state_nx;
   logic [ADC_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [CW-1:0]    fill, fill_nx;
   logic [GW-1:0]    gap_cnt, gap_nx;
   logic [SW-1:0]    smp_cnt, smp_nx;
   logic             push, pop, epoch_inc;

   logic             adc_ready_q;
   logic             new_sleep_epoch_q;
   logic             start_eeg_load_q;
   logic             new_eeg_data_q;
   logic [ADC_W-1:0] eeg_q;
   logic             busy_q;
   logic             overflow_q;
   logic [15:0]      epoch_cnt;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next state, pop decision and pacing/sample counters
   always_comb begin
      state_nx  = state;
      pop       = 1'b0;
      epoch_inc = 1'b0;
      smp_nx    = smp_cnt;
      gap_nx    = (gap_cnt != '0) ? gap_cnt - GW'(1) : gap_cnt;
      case (state)
         S_IDLE: begin
            if (bus.enable && (fill != '0)) state_nx = S_EPOCH;
         end
         S_EPOCH: state_nx = S_LOAD;
         S_LOAD: begin
            gap_nx   = '0;
            smp_nx   = '0;
            state_nx = S_STREAM;
         end
         S_STREAM: begin
            if ((fill != '0) && (gap_cnt == '0)) begin
               pop    = 1'b1;
               gap_nx = GW'(LOAD_GAP);
               smp_nx = smp_cnt + SW'(1);
               if (smp_cnt == SW'(SAMPLES_PER_EPOCH - 1)) state_nx = S_WAIT_INF;
            end
         end
         S_WAIT_INF: begin
            if (bus.inference_complete) begin
               epoch_inc = 1'b1;
               state_nx  = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Push uses the registered ready, so a full FIFO refuses even with a concurrent pop
   assign push    = bus.adc_valid && adc_ready_q;
   assign fill_nx = fill + CW'(push) - CW'(pop);

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.adc_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr            <= '0;
         rd_ptr            <= '0;
         fill              <= '0;
         gap_cnt           <= '0;
         smp_cnt           <= '0;
         adc_ready_q       <= 1'b1;
         new_sleep_epoch_q <= 1'b0;
         start_eeg_load_q  <= 1'b0;
         new_eeg_data_q    <= 1'b0;
         eeg_q             <= '0;
         busy_q            <= 1'b0;
         overflow_q        <= 1'b0;
         epoch_cnt         <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         fill              <= fill_nx;
         gap_cnt           <= gap_nx;
         smp_cnt           <= smp_nx;
         adc_ready_q       <= (fill_nx != CW'(FIFO_DEPTH));
         new_sleep_epoch_q <= (state_nx == S_EPOCH);
         start_eeg_load_q  <= (state_nx == S_LOAD);
         new_eeg_data_q    <= pop;
         if (pop) eeg_q    <= mem[rd_ptr];
         busy_q            <= (state_nx != S_IDLE);
         if (bus.adc_valid && !adc_ready_q) overflow_q <= 1'b1;
         if (epoch_inc) epoch_cnt <= epoch_cnt + 16'd1;
      end
   end

   assign bus.adc_ready       = adc_ready_q;
   assign bus.new_sleep_epoch = new_sleep_epoch_q;
   assign bus.start_eeg_load  = start_eeg_load_q;
   assign bus.new_eeg_data    = new_eeg_data_q;
   assign bus.eeg             = eeg_q;
   assign bus.busy            = busy_q;
   assign bus.overflow        = overflow_q;
   assign bus.epoch_count     = epoch_cnt;

endmodule
